rr_sel_arbiter: RTL and testbench

Round-robin arbiter that turns a vector of requests into a registered 2-bit `sel` index with a valid/ready handshake. It sits directly upstream of the sel-driven decoders (unique case / unique if / priority if on `sel`). Only indices below NUM_REQ are ever driven, so a downstream `unique case` with no default never sees an uncovered value. It also includes a grant-timeout watchdog, so a stalled consumer cannot lock out the other requesters.

---
 rtl/arb_pkg.sv | 15 +
 rtl/rr_sel_arbiter_if.sv | 22 ++
 rtl/rr_find_first.sv | 33 +++
 rtl/rr_sel_arbiter.sv | 113 +++++++++++
 tb/tb_rr_sel_arbiter.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared types and width helpers for the round-robin sel arbiter.
package arb_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_e;

    function automatic int sel_w(int num_req);
        return (num_req < 2) ? 1 : $clog2(num_req);
    endfunction

    // A disabled watchdog still keeps a 1-bit counter so widths stay legal.
    function automatic int cnt_w(int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/rr_sel_arbiter_if.sv
// Request/grant bundle between requesters, consumer and the arbiter.
interface rr_sel_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int SEL_W   = 2
);
    logic [NUM_REQ-1:0] req;
    logic               gnt_ready;
    logic               gnt_valid;
    logic [SEL_W-1:0]   sel;
    logic [NUM_REQ-1:0] gnt_onehot;
    logic               timeout_err;

    modport master (
        input  req, gnt_ready,
        output gnt_valid, sel, gnt_onehot, timeout_err
    );

    modport slave (
        output req, gnt_ready,
        input  gnt_valid, sel, gnt_onehot, timeout_err
    );
endinterface

// File: rtl/rr_find_first.sv
// First set request at or above ptr, wrapping modulo NUM_REQ (NUM_REQ <= 4).
module rr_find_first #(
    parameter int NUM_REQ = 3,
    parameter int SEL_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [3:0]           r4;
    logic [1:0]           off;
    logic [2:0]           sum;

    always_comb begin
        dbl   = {req, req};
        rot   = NUM_REQ'(dbl >> ptr);
        r4    = 4'(rot);
        found = |rot;
        priority if (r4[0]) off = 2'd0;
        else if (r4[1])     off = 2'd1;
        else if (r4[2])     off = 2'd2;
        else if (r4[3])     off = 2'd3;
        else                off = 2'd0;
        sum = 3'(off) + 3'(ptr);
        if (sum >= 3'(NUM_REQ)) begin
            sum = sum - 3'(NUM_REQ);
        end
        idx = SEL_W'(sum);
    end
endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter with registered sel/one-hot grant and grant watchdog.
module rr_sel_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int SEL_W   = 2,
    parameter int TIMEOUT = 8
) (
    input logic           clk,
    input logic           rst_n,
    rr_sel_arbiter_if.master bus
);
    localparam int CW = cnt_w(TIMEOUT);
    localparam logic [CW-1:0] WAIT_LAST =
        CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REQ - 1);

    arb_state_e         state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]      wait_q, wait_d;
    logic               valid_q, valid_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [NUM_REQ-1:0] onehot_q, onehot_d;
    logic               err_q, err_d;

    logic [SEL_W-1:0]   sel_inc;
    logic [SEL_W-1:0]   ff_ptr;
    logic               found;
    logic [SEL_W-1:0]   pick;

    assign sel_inc = (sel_q == LAST_IDX) ? '0 : sel_q + SEL_W'(1);
    // In GRANT the pick only matters on a handshake, which advances ptr.
    assign ff_ptr  = (state_q == GRANT) ? sel_inc : ptr_q;

    rr_find_first #(
        .NUM_REQ (NUM_REQ),
        .SEL_W   (SEL_W)
    ) u_find (
        .req   (bus.req),
        .ptr   (ff_ptr),
        .found (found),
        .idx   (pick)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        wait_d   = wait_q;
        valid_d  = valid_q;
        sel_d    = sel_q;
        onehot_d = onehot_q;
        err_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d  = GRANT;
                    valid_d  = 1'b1;
                    sel_d    = pick;
                    onehot_d = NUM_REQ'(1) << pick;
                    wait_d   = '0;
                end
            end
            GRANT: begin
                if (bus.gnt_ready) begin
                    ptr_d = sel_inc;
                    if (found) begin
                        sel_d    = pick;
                        onehot_d = NUM_REQ'(1) << pick;
                        wait_d   = '0;
                    end else begin
                        state_d  = IDLE;
                        valid_d  = 1'b0;
                        onehot_d = '0;
                    end
                end else if (TIMEOUT > 0 && wait_q == WAIT_LAST) begin
                    state_d  = IDLE;
                    valid_d  = 1'b0;
                    onehot_d = '0;
                    err_d    = 1'b1;
                    ptr_d    = sel_inc;
                    wait_d   = '0;
                end else if (wait_q != '1) begin
                    wait_d = wait_q + CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            wait_q   <= '0;
            valid_q  <= 1'b0;
            sel_q    <= '0;
            onehot_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            wait_q   <= wait_d;
            valid_q  <= valid_d;
            sel_q    <= sel_d;
            onehot_q <= onehot_d;
            err_q    <= err_d;
        end
    end

    assign bus.gnt_valid   = valid_q;
    assign bus.sel         = sel_q;
    assign bus.gnt_onehot  = onehot_q;
    assign bus.timeout_err = err_q;
endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Scoreboard bench for rr_sel_arbiter (NUM_REQ=3; TIMEOUT=8 and TIMEOUT=0).
module tb_rr_sel_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rr_sel_arbiter_if #(.NUM_REQ(3), .SEL_W(2)) bus ();
    rr_sel_arbiter_if #(.NUM_REQ(3), .SEL_W(2)) bus0 ();

    rr_sel_arbiter #(.NUM_REQ(3), .SEL_W(2), .TIMEOUT(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    rr_sel_arbiter #(.NUM_REQ(3), .SEL_W(2), .TIMEOUT(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    typedef struct packed {
        logic [1:0] sel;
        logic       to;
    } exp_t;

    exp_t exp_q[$];
    int n_chk = 0;
    int n_fail = 0;
    int gcnt = 0;
    logic pv = 1'b0, pr = 1'b0, pe = 1'b0;
    logic [1:0] ps = 2'd0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(logic [1:0] s, logic to);
        exp_t e;
        e.sel = s;
        e.to  = to;
        exp_q.push_back(e);
    endtask

    // Monitor: pops expected grants on handshake / watchdog revocation.
    initial begin
        logic [2:0] oh;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                oh = 3'b001 << bus.sel;
                chk("onehot_match", 32'(bus.gnt_onehot),
                    bus.gnt_valid ? 32'(oh) : 32'd0);
                if (bus.timeout_err) chk("err_twice", 32'(pe), 32'd0);
                if (pv && !pr && bus.gnt_valid)
                    chk("sel_stable", 32'(bus.sel), 32'(ps));
                if (bus.gnt_valid) begin
                    gcnt++;
                    chk("sel_range", 32'(bus.sel < 2'd3), 32'd1);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_grant", 32'd1, 32'd0);
                    end else begin
                        chk("sel", 32'(bus.sel), 32'(exp_q[0].sel));
                        if (bus.gnt_ready) begin
                            chk("hs_not_timeout", 32'(exp_q[0].to), 32'd0);
                            void'(exp_q.pop_front());
                            gcnt = 0;
                        end
                    end
                end
                if (bus.timeout_err) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_timeout", 32'd1, 32'd0);
                    end else begin
                        chk("timeout_expected", 32'(exp_q[0].to), 32'd1);
                        chk("timeout_len", 32'(gcnt), 32'd8);
                        void'(exp_q.pop_front());
                    end
                    gcnt = 0;
                end
                pv = bus.gnt_valid;
                pr = bus.gnt_ready;
                pe = bus.timeout_err;
                ps = bus.sel;
            end else begin
                pv = 1'b0;
                pe = 1'b0;
                gcnt = 0;
            end
        end
    end

    initial begin
        bus.req = 3'b000;
        bus.gnt_ready = 1'b0;
        bus0.req = 3'b000;
        bus0.gnt_ready = 1'b0;
        cyc(2);
        chk("rst_valid", 32'(bus.gnt_valid), 32'd0);
        chk("rst_sel", 32'(bus.sel), 32'd0);
        chk("rst_onehot", 32'(bus.gnt_onehot), 32'd0);
        chk("rst_err", 32'(bus.timeout_err), 32'd0);
        chk("rst_ptr", 32'(dut.ptr_q), 32'd0);
        rst_n = 1'b1;
        cyc(1);

        // Single request, immediate handshake, then idle.
        bus.req = 3'b010;
        bus.gnt_ready = 1'b1;
        push(2'd1, 1'b0);
        cyc(1);
        chk("b_valid", 32'(bus.gnt_valid), 32'd1);
        chk("b_onehot", 32'(bus.gnt_onehot), 32'b010);
        bus.req = 3'b000;
        cyc(1);
        chk("b_idle", 32'(bus.gnt_valid), 32'd0);
        chk("b_ptr", 32'(dut.ptr_q), 32'd2);

        // Wrap from ptr=2 with req=011.
        bus.req = 3'b011;
        push(2'd0, 1'b0);
        push(2'd1, 1'b0);
        cyc(1);
        chk("c_valid0", 32'(bus.gnt_valid), 32'd1);
        cyc(1);
        chk("c_valid1", 32'(bus.gnt_valid), 32'd1);
        bus.req = 3'b000;
        cyc(1);
        chk("c_idle", 32'(bus.gnt_valid), 32'd0);

        // Async reset in the middle of a sel=2 grant.
        bus.req = 3'b100;
        bus.gnt_ready = 1'b0;
        cyc(1);
        chk("d_pre_sel", 32'(bus.sel), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("d_rst_valid", 32'(bus.gnt_valid), 32'd0);
        chk("d_rst_sel", 32'(bus.sel), 32'd0);
        chk("d_rst_onehot", 32'(bus.gnt_onehot), 32'd0);
        bus.req = 3'b000;
        exp_q.delete();
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        chk("d_stay_idle", 32'(bus.gnt_valid), 32'd0);

        // All requesting: back-to-back grants 0,1,2,0,1.
        bus.gnt_ready = 1'b1;
        bus.req = 3'b111;
        push(2'd0, 1'b0);
        push(2'd1, 1'b0);
        push(2'd2, 1'b0);
        push(2'd0, 1'b0);
        push(2'd1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("e_no_bubble", 32'(bus.gnt_valid), 32'd1);
        end
        bus.req = 3'b000;
        cyc(1);
        chk("e_idle", 32'(bus.gnt_valid), 32'd0);

        // Backpressure for 3 cycles, accepted on the 4th.
        bus.req = 3'b001;
        bus.gnt_ready = 1'b0;
        push(2'd0, 1'b0);
        cyc(1);
        for (int i = 0; i < 4; i++) begin
            chk("f_hold_sel", 32'(bus.sel), 32'd0);
            chk("f_valid", 32'(bus.gnt_valid), 32'd1);
            chk("f_no_err", 32'(bus.timeout_err), 32'd0);
            if (i == 3) begin
                bus.gnt_ready = 1'b1;
                bus.req = 3'b000;
            end
            cyc(1);
        end
        chk("f_idle", 32'(bus.gnt_valid), 32'd0);
        chk("f_no_err_end", 32'(bus.timeout_err), 32'd0);

        // Watchdog revocation after 8 stalled grant cycles.
        bus.req = 3'b100;
        bus.gnt_ready = 1'b0;
        push(2'd2, 1'b1);
        cyc(1);
        for (int i = 0; i < 8; i++) begin
            chk("g_valid", 32'(bus.gnt_valid), 32'd1);
            chk("g_no_err", 32'(bus.timeout_err), 32'd0);
            cyc(1);
        end
        chk("g_revoked", 32'(bus.gnt_valid), 32'd0);
        chk("g_onehot0", 32'(bus.gnt_onehot), 32'd0);
        chk("g_err", 32'(bus.timeout_err), 32'd1);
        chk("g_ptr", 32'(dut.ptr_q), 32'd0);
        push(2'd2, 1'b0);
        bus.gnt_ready = 1'b1;
        cyc(1);
        chk("g_regrant", 32'(bus.gnt_valid), 32'd1);
        chk("g_err_pulse", 32'(bus.timeout_err), 32'd0);
        chk("g_regrant_sel", 32'(bus.sel), 32'd2);
        bus.req = 3'b000;
        cyc(1);
        chk("g_idle", 32'(bus.gnt_valid), 32'd0);

        // Handshake in the same cycle the watchdog would fire.
        bus.req = 3'b100;
        bus.gnt_ready = 1'b0;
        push(2'd2, 1'b0);
        cyc(1);
        for (int i = 0; i < 7; i++) begin
            chk("h_valid", 32'(bus.gnt_valid), 32'd1);
            cyc(1);
        end
        chk("h_valid8", 32'(bus.gnt_valid), 32'd1);
        bus.gnt_ready = 1'b1;
        bus.req = 3'b000;
        cyc(1);
        chk("h_idle", 32'(bus.gnt_valid), 32'd0);
        chk("h_no_err", 32'(bus.timeout_err), 32'd0);
        cyc(1);
        chk("h_no_err2", 32'(bus.timeout_err), 32'd0);

        // Watchdog disabled: grant held indefinitely.
        bus0.req = 3'b001;
        bus0.gnt_ready = 1'b0;
        cyc(1);
        for (int i = 0; i < 50; i++) begin
            chk("i_held", 32'(bus0.gnt_valid), 32'd1);
            chk("i_no_err", 32'(bus0.timeout_err), 32'd0);
            cyc(1);
        end
        bus0.gnt_ready = 1'b1;
        bus0.req = 3'b000;
        cyc(1);
        chk("i_idle", 32'(bus0.gnt_valid), 32'd0);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
